// File: rtl/yacht_pkg.sv
// Shared encodings for the Yacht scoring engine: categories, fixed scores, FSM states.
package yacht_pkg;

  localparam int unsigned NUM_CATS = 12;
  localparam int unsigned HIST_W   = 3;

  localparam logic [3:0] CAT_ONES           = 4'd0;
  localparam logic [3:0] CAT_TWOS           = 4'd1;
  localparam logic [3:0] CAT_THREES         = 4'd2;
  localparam logic [3:0] CAT_FOURS          = 4'd3;
  localparam logic [3:0] CAT_FIVES          = 4'd4;
  localparam logic [3:0] CAT_SIXES          = 4'd5;
  localparam logic [3:0] CAT_CHOICE         = 4'd6;
  localparam logic [3:0] CAT_FOUR_KIND      = 4'd7;
  localparam logic [3:0] CAT_FULL_HOUSE     = 4'd8;
  localparam logic [3:0] CAT_SMALL_STRAIGHT = 4'd9;
  localparam logic [3:0] CAT_LARGE_STRAIGHT = 4'd10;
  localparam logic [3:0] CAT_YACHT          = 4'd11;

  localparam logic [7:0] SCORE_FULL_HOUSE     = 8'd25;
  localparam logic [7:0] SCORE_SMALL_STRAIGHT = 8'd30;
  localparam logic [7:0] SCORE_LARGE_STRAIGHT = 8'd40;
  localparam logic [7:0] SCORE_YACHT          = 8'd50;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_EVAL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/yacht_face_hist.sv
// Serial face histogram: one die per valid cycle, sticky flag for out-of-range dice.
module yacht_face_hist
  import yacht_pkg::*;
#(
  parameter int unsigned FACES = 6,
  parameter int unsigned DIE_W = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          valid,
  input  logic [DIE_W-1:0]              die,
  output logic [FACES-1:0][HIST_W-1:0]  hist,
  output logic                          bad
);

  logic [FACES-1:0][HIST_W-1:0] hist_q, hist_d;
  logic                         bad_q, bad_d;

  // Next histogram: clear on a new roll, else bump the count of a legal face (face f at index f-1).
  always_comb begin
    hist_d = hist_q;
    bad_d  = bad_q;
    if (clear) begin
      hist_d = '0;
      bad_d  = 1'b0;
    end else if (valid) begin
      if (die == '0 || die > DIE_W'(FACES)) begin
        bad_d = 1'b1;
      end else begin
        for (int unsigned f = 0; f < FACES; f++) begin
          if (die == DIE_W'(f + 1)) begin
            hist_d[f] = hist_q[f] + HIST_W'(1);
          end
        end
      end
    end
  end

  // Histogram and bad-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      bad_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      bad_q  <= bad_d;
    end
  end

  assign hist = hist_q;
  assign bad  = bad_q;

endmodule

// File: rtl/yacht_score_engine.sv
// Yacht scoring engine: latch roll, build histogram, evaluate category, update scorecard.
module yacht_score_engine
  import yacht_pkg::*;
#(
  parameter int unsigned FACES     = 6,
  parameter int unsigned DIE_W     = 4,
  parameter int unsigned SCORE_W   = 10,
  parameter int unsigned BONUS_TH  = 63,
  parameter int unsigned BONUS_VAL = 35
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  commit,
  input  logic                  new_game,
  input  logic [3:0]            cat,
  input  logic [5*DIE_W-1:0]    dice,
  output logic                  busy,
  output logic                  score_valid,
  output logic [SCORE_W-1:0]    score,
  output logic                  reject,
  output logic                  bad_die,
  output logic [NUM_CATS-1:0]   used,
  output logic [SCORE_W-1:0]    total,
  output logic                  bonus_got,
  output logic                  game_over
);

  state_e                     state_q, state_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [4:0][DIE_W-1:0]      dice_q, dice_d;
  logic [3:0]                 cat_q, cat_d;
  logic                       commit_q, commit_d;
  logic [SCORE_W-1:0]         eval_q, eval_d;
  logic                       score_valid_q, score_valid_d;
  logic [SCORE_W-1:0]         score_q, score_d;
  logic                       reject_q, reject_d;
  logic                       bad_die_q, bad_die_d;
  logic [NUM_CATS-1:0]        used_q, used_d;
  logic [SCORE_W-1:0]         total_q, total_d;
  logic [SCORE_W-1:0]         upper_q, upper_d;
  logic                       bonus_q, bonus_d;

  logic                       accept;
  logic [FACES-1:0][HIST_W-1:0] hist;
  logic                       hist_bad;
  logic [7:0]                 face_sum, raw_score;
  logic                       has2, has3, has4, has5, run4, run5;
  logic                       used_hit, refuse;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  assign accept    = (state_q == ST_IDLE) && req && !new_game;
  assign game_over = &used_q;

  yacht_face_hist #(
    .FACES(FACES),
    .DIE_W(DIE_W)
  ) u_hist (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .valid (state_q == ST_COUNT),
    .die   (dice_q[cnt_q]),
    .hist  (hist),
    .bad   (hist_bad)
  );

  // Category evaluation and commit-refusal decision over the finished histogram.
  always_comb begin
    face_sum = '0;
    has2 = 1'b0;
    has3 = 1'b0;
    has4 = 1'b0;
    has5 = 1'b0;
    run4 = 1'b0;
    run5 = 1'b0;
    for (int unsigned f = 0; f < FACES; f++) begin
      face_sum = face_sum + 8'(hist[f]) * 8'(f + 1);
      if (hist[f] == HIST_W'(2)) has2 = 1'b1;
      if (hist[f] == HIST_W'(3)) has3 = 1'b1;
      if (hist[f] >= HIST_W'(4)) has4 = 1'b1;
      if (hist[f] == HIST_W'(5)) has5 = 1'b1;
    end
    for (int unsigned i = 0; i + 4 <= FACES; i++) begin
      if (hist[i] != '0 && hist[i+1] != '0 && hist[i+2] != '0 && hist[i+3] != '0)
        run4 = 1'b1;
    end
    for (int unsigned i = 0; i + 5 <= FACES; i++) begin
      if (hist[i] != '0 && hist[i+1] != '0 && hist[i+2] != '0 && hist[i+3] != '0 &&
          hist[i+4] != '0)
        run5 = 1'b1;
    end

    raw_score = '0;
    case (cat_q)
      CAT_CHOICE:         raw_score = face_sum;
      CAT_FOUR_KIND:      raw_score = has4 ? face_sum : '0;
      CAT_FULL_HOUSE:     raw_score = ((has3 && has2) || has5) ? SCORE_FULL_HOUSE : '0;
      CAT_SMALL_STRAIGHT: raw_score = run4 ? SCORE_SMALL_STRAIGHT : '0;
      CAT_LARGE_STRAIGHT: raw_score = run5 ? SCORE_LARGE_STRAIGHT : '0;
      CAT_YACHT:          raw_score = has5 ? SCORE_YACHT : '0;
      default: begin
        for (int unsigned c = 0; c < 6; c++) begin
          if (cat_q == 4'(c)) raw_score = 8'(hist[c]) * 8'(c + 1);
        end
      end
    endcase
    if (hist_bad || cat_q > CAT_YACHT) raw_score = '0;

    used_hit = 1'b0;
    for (int unsigned c = 0; c < NUM_CATS; c++) begin
      if (cat_q == 4'(c)) used_hit = used_q[c];
    end
    refuse = commit_q && (used_hit || cat_q > CAT_YACHT || hist_bad || game_over);
  end

  // Sequencer and scorecard next-state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dice_d        = dice_q;
    cat_d         = cat_q;
    commit_d      = commit_q;
    eval_d        = eval_q;
    score_valid_d = 1'b0;
    score_d       = score_q;
    reject_d      = reject_q;
    bad_die_d     = bad_die_q;
    used_d        = used_q;
    total_d       = total_q;
    upper_d       = upper_q;
    bonus_d       = bonus_q;
    case (state_q)
      ST_IDLE: begin
        if (new_game) begin
          used_d  = '0;
          total_d = '0;
          upper_d = '0;
          bonus_d = 1'b0;
        end else if (req) begin
          dice_d   = dice;
          cat_d    = cat;
          commit_d = commit;
          cnt_d    = '0;
          state_d  = ST_COUNT;
        end
      end
      ST_COUNT: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd4) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        eval_d  = SCORE_W'(raw_score);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        score_valid_d = 1'b1;
        score_d       = eval_q;
        bad_die_d     = hist_bad;
        reject_d      = refuse;
        if (commit_q && !refuse) begin
          used_d  = used_q | (NUM_CATS'(1) << cat_q);
          total_d = sat_add(total_q, eval_q);
          if (cat_q <= CAT_SIXES) begin
            upper_d = sat_add(upper_q, eval_q);
            // Bonus lands in the same update that first crosses the threshold.
            if (!bonus_q && upper_d >= SCORE_W'(BONUS_TH)) begin
              total_d = sat_add(total_d, SCORE_W'(BONUS_VAL));
              bonus_d = 1'b1;
            end
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched request and scorecard registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      dice_q        <= '0;
      cat_q         <= '0;
      commit_q      <= 1'b0;
      eval_q        <= '0;
      score_valid_q <= 1'b0;
      score_q       <= '0;
      reject_q      <= 1'b0;
      bad_die_q     <= 1'b0;
      used_q        <= '0;
      total_q       <= '0;
      upper_q       <= '0;
      bonus_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dice_q        <= dice_d;
      cat_q         <= cat_d;
      commit_q      <= commit_d;
      eval_q        <= eval_d;
      score_valid_q <= score_valid_d;
      score_q       <= score_d;
      reject_q      <= reject_d;
      bad_die_q     <= bad_die_d;
      used_q        <= used_d;
      total_q       <= total_d;
      upper_q       <= upper_d;
      bonus_q       <= bonus_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign score_valid = score_valid_q;
  assign score       = score_q;
  assign reject      = reject_q;
  assign bad_die     = bad_die_q;
  assign used        = used_q;
  assign total       = total_q;
  assign bonus_got   = bonus_q;

endmodule

// File: tb/tb_yacht_score_engine.sv
// Scoreboard bench for yacht_score_engine with an 8-face die configuration.
module tb_yacht_score_engine;

  localparam int unsigned FACES   = 8;
  localparam int unsigned DIE_W   = 4;
  localparam int unsigned SCORE_W = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req = 1'b0;
  logic                 commit = 1'b0;
  logic                 new_game = 1'b0;
  logic [3:0]           cat = '0;
  logic [5*DIE_W-1:0]   dice = '0;
  logic                 busy, score_valid, reject, bad_die, bonus_got, game_over;
  logic [SCORE_W-1:0]   score, total;
  logic [11:0]          used;

  yacht_score_engine #(
    .FACES    (FACES),
    .DIE_W    (DIE_W),
    .SCORE_W  (SCORE_W),
    .BONUS_TH (63),
    .BONUS_VAL(35)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .commit     (commit),
    .new_game   (new_game),
    .cat        (cat),
    .dice       (dice),
    .busy       (busy),
    .score_valid(score_valid),
    .score      (score),
    .reject     (reject),
    .bad_die    (bad_die),
    .used       (used),
    .total      (total),
    .bonus_got  (bonus_got),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    int          score;
    bit          rej;
    bit          bad;
    logic [11:0] used;
    int          total;
    bit          bonus;
    bit          go;
    int          t0;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic roll(input int id, input int d0, input int d1, input int d2, input int d3,
                      input int d4, input int c, input bit cm, input int e_score,
                      input bit e_rej, input bit e_bad, input int e_used, input int e_total,
                      input bit e_bonus, input bit e_go);
    exp_t e;
    @(negedge clk);
    dice   = {DIE_W'(d4), DIE_W'(d3), DIE_W'(d2), DIE_W'(d1), DIE_W'(d0)};
    cat    = 4'(c);
    commit = cm;
    req    = 1'b1;
    @(posedge clk);
    #1;
    req    = 1'b0;
    dice   = '0;
    cat    = '0;
    commit = 1'b0;
    e.id = id; e.score = e_score; e.rej = e_rej; e.bad = e_bad; e.used = 12'(e_used);
    e.total = e_total; e.bonus = e_bonus; e.go = e_go; e.t0 = cyc;
    sbq.push_back(e);
    check($sformatf("step%0d_busy_after_req", id), busy, 1);
    for (int n = 0; n < 20 && busy; n++) @(negedge clk);
    if (busy) check($sformatf("step%0d_timeout", id), busy, 0);
  endtask

  // Monitor: compare every result pulse against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (score_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sbq.pop_front();
          check($sformatf("step%0d_latency", e.id), cyc - e.t0, 7);
          check($sformatf("step%0d_score", e.id), score, e.score);
          check($sformatf("step%0d_reject", e.id), reject, e.rej);
          check($sformatf("step%0d_bad_die", e.id), bad_die, e.bad);
          check($sformatf("step%0d_used", e.id), used, e.used);
          check($sformatf("step%0d_total", e.id), total, e.total);
          check($sformatf("step%0d_bonus", e.id), bonus_got, e.bonus);
          check($sformatf("step%0d_game_over", e.id), game_over, e.go);
          @(negedge clk);
          check($sformatf("step%0d_pulse_width", e.id), score_valid, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_score_valid", score_valid, 0);
    check("rst_score", score, 0);
    check("rst_reject", reject, 0);
    check("rst_bad_die", bad_die, 0);
    check("rst_used", used, 0);
    check("rst_total", total, 0);
    check("rst_bonus", bonus_got, 0);
    check("rst_game_over", game_over, 0);

    //    id  d0 d1 d2 d3 d4 cat cm score rej bad used    total bon go
    roll( 1, 3, 3, 3, 5, 5,  8, 1, 25,  0,  0, 12'h100,  25, 0, 0);
    roll( 2, 3, 3, 3, 5, 5,  8, 1, 25,  1,  0, 12'h100,  25, 0, 0);
    roll( 3, 4, 5, 6, 7, 8, 10, 0, 40,  0,  0, 12'h100,  25, 0, 0);
    roll( 4, 7, 7, 7, 7, 2,  7, 0, 30,  0,  0, 12'h100,  25, 0, 0);
    roll( 5, 3, 3, 3, 5, 6,  8, 0,  0,  0,  0, 12'h100,  25, 0, 0);
    roll( 6, 1, 2, 0, 4, 5,  6, 1,  0,  1,  1, 12'h100,  25, 0, 0);
    roll( 7, 8, 8, 8, 9, 8,  6, 0,  0,  0,  1, 12'h100,  25, 0, 0);
    roll( 8, 5, 6, 7, 8, 1,  9, 0, 30,  0,  0, 12'h100,  25, 0, 0);
    roll( 9, 1, 2, 3, 4, 6, 10, 0,  0,  0,  0, 12'h100,  25, 0, 0);
    roll(10, 8, 8, 8, 8, 7, 11, 0,  0,  0,  0, 12'h100,  25, 0, 0);
    roll(11, 1, 1, 1, 1, 1, 13, 1,  0,  1,  0, 12'h100,  25, 0, 0);

    // new_game together with req: scorecard clears, request is dropped
    @(negedge clk);
    new_game = 1'b1;
    req      = 1'b1;
    dice     = {4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    cat      = 4'd0;
    commit   = 1'b1;
    @(posedge clk);
    #1;
    new_game = 1'b0;
    req      = 1'b0;
    commit   = 1'b0;
    check("ng_busy", busy, 0);
    check("ng_used", used, 0);
    check("ng_total", total, 0);
    check("ng_bonus", bonus_got, 0);
    repeat (10) @(negedge clk);
    check("ng_busy_later", busy, 0);

    roll(12, 6, 6, 6, 6, 6,  5, 1, 30,  0,  0, 12'h020,  30, 0, 0);
    roll(13, 5, 5, 5, 5, 5,  4, 1, 25,  0,  0, 12'h030,  55, 0, 0);
    roll(14, 4, 4, 4, 4, 1,  3, 1, 16,  0,  0, 12'h038, 106, 1, 0);
    roll(15, 1, 1, 2, 3, 4,  0, 1,  2,  0,  0, 12'h039, 108, 1, 0);
    roll(16, 2, 2, 2, 3, 3,  1, 1,  6,  0,  0, 12'h03B, 114, 1, 0);
    roll(17, 3, 3, 1, 1, 1,  2, 1,  6,  0,  0, 12'h03F, 120, 1, 0);
    roll(18, 1, 2, 3, 4, 8,  6, 1, 18,  0,  0, 12'h07F, 138, 1, 0);
    roll(19, 2, 2, 2, 2, 2,  7, 1, 10,  0,  0, 12'h0FF, 148, 1, 0);
    roll(20, 5, 5, 5, 5, 5,  8, 1, 25,  0,  0, 12'h1FF, 173, 1, 0);
    roll(21, 2, 3, 4, 5, 5,  9, 1, 30,  0,  0, 12'h3FF, 203, 1, 0);
    roll(22, 3, 4, 5, 6, 7, 10, 1, 40,  0,  0, 12'h7FF, 243, 1, 0);
    roll(23, 8, 8, 8, 8, 8, 11, 1, 50,  0,  0, 12'hFFF, 293, 1, 1);
    roll(24, 1, 1, 1, 1, 1, 11, 1, 50,  1,  0, 12'hFFF, 293, 1, 1);
    roll(25, 3, 3, 3, 3, 3, 11, 0, 50,  0,  0, 12'hFFF, 293, 1, 1);
    roll(26, 6, 6, 6, 6, 6, 12, 0,  0,  0,  0, 12'hFFF, 293, 1, 1);

    // reset while counting: request aborted, everything back to zero
    @(negedge clk);
    dice   = {4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
    cat    = 4'd11;
    commit = 1'b1;
    req    = 1'b1;
    @(posedge clk);
    #1;
    req    = 1'b0;
    commit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_in_count", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy_async", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_score_valid", score_valid, 0);
    check("abort_score", score, 0);
    check("abort_reject", reject, 0);
    check("abort_bad_die", bad_die, 0);
    check("abort_used", used, 0);
    check("abort_total", total, 0);
    check("abort_bonus", bonus_got, 0);
    check("abort_game_over", game_over, 0);

    repeat (3) @(negedge clk);
    check("pending_results", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/yacht_score_engine.md
# yacht_score_engine

Sequential, parametrised scoring engine for the Yacht dice game. It accepts a 5-die roll and a category on a request handshake, builds a face histogram one die per cycle, and evaluates the category score. It can also commit that score into an internal 12-category scorecard, which tracks used categories, the upper-section sum with a one-time bonus, the running total and game-over. It sits between the roll/hold controller and the display driver.

## Interface
- FACES, default 6: faces per die, legal range 6..15; legal die values are 1..FACES.
- DIE_W, default 4: die value width; must satisfy 2^DIE_W > FACES.
- SCORE_W, default 10: width of the score and total outputs.
- BONUS_TH, default 63: threshold on the upper-section sum.
- BONUS_VAL, default 35: bonus added once when the upper sum reaches BONUS_TH.
- clk  in  1: single clock, rising edge.
- rst  in  1: reset, asynchronous and active-high.
- req  in  1: scoring request, accepted only in IDLE.
- commit  in  1: sampled with req; 1 = write the score to the scorecard, 0 = preview only.
- new_game  in  1: clears the scorecard; honoured only in IDLE.
- cat  in  4: category 0..11 (Ones..Sixes, Choice, FourKind, FullHouse, SmallStraight, LargeStraight, Yacht).
- dice  in  5*DIE_W: die k occupies bits [k*DIE_W +: DIE_W].
- busy  out  1: high in every state except IDLE.
- score_valid  out  1: one-cycle pulse marking the result.
- score  out  SCORE_W: evaluated score, held until the next result.
- reject  out  1: qualified by score_valid; the commit was refused.
- bad_die  out  1: qualified by score_valid; at least one die was outside 1..FACES.
- used  out  12: scorecard used-category mask.
- total  out  SCORE_W: running total, including the bonus.
- bonus_got  out  1: the bonus has been awarded.
- game_over  out  1: all 12 categories are used.

## Operation
- States are IDLE, COUNT, EVAL and DONE.
- IDLE:
  - req=1 latches dice, cat and commit, clears the histogram and moves to COUNT.
  - req is ignored while busy; there is no queue.
- COUNT:
  - Five cycles; die index 0..4 is processed in order.
  - A legal value increments hist[value].
  - An illegal value (0 or >FACES) sets a sticky bad flag and leaves the histogram unchanged.
- EVAL: one cycle, combinational over the histogram, result registered.
  - Faces 1..6 map to categories 0..5: score = hist[f]*f.
  - Choice = sum of the dice.
  - FourKind: sum if any hist ≥4, else 0.
  - FullHouse: 25 if one face has count 3 and another has count 2, or any count is 5; else 0.
  - SmallStraight: 30 if any run of 4 consecutive present faces exists within 1..FACES.
  - LargeStraight: 40 if any run of 5 exists.
  - Yacht: 50 if any count is 5.
  - Straight checks span all FACES, not just 1..6.
  - Upper categories for faces 7..FACES do not exist; faces above 6 count only toward Choice, FourKind and the straights.
- Score is forced to 0 if bad=1 or cat ≥12.
- DONE: one cycle. score_valid=1, then return to IDLE.
- Commit decision in DONE:
  - Reject when commit=1 and any of: used[cat]=1, cat ≥12, bad=1, or game_over=1. On reject the scorecard is unchanged.
  - Otherwise, when commit=1:
    - set used[cat];
    - add score to total;
    - for cat ≤5, add score to upper_sum;
    - if upper_sum first reaches ≥BONUS_TH, add BONUS_VAL in the same update and set bonus_got.
  - With commit=0, reject=0 and the scorecard is unchanged.
- new_game in IDLE clears used, total, upper_sum and bonus_got. If req is also high in that cycle, new_game wins and req is dropped.
- Arithmetic: all adds are unsigned and saturate at 2^SCORE_W−1. upper_sum is an internal counter of width SCORE_W.

## Timing
- Request accepted at edge E0 (req=1 while in IDLE).
- COUNT covers edges E1..E5; EVAL registers at E6.
- score_valid, score, reject, bad_die and the updated used/total/bonus_got/game_over all become visible after E7.
- Latency is 7 cycles, request edge to result.
- busy is high from after E0 through E7, low after E7.
- The earliest next req is accepted at E8; a req held high continuously yields one result every 8 cycles.
- Dice and cat may change after E0; the engine uses only the latched copies.
- Reset values: busy=0, score_valid=0, score=0, reject=0, bad_die=0, used=0, total=0, bonus_got=0, game_over=0, state=IDLE.
- Reset mid-operation aborts the request with no result pulse.

## Structure
- yacht_pkg holds:
  - category encodings CAT_ONES..CAT_YACHT and NUM_CATS=12;
  - fixed scores 25/30/40/50;
  - the state enum.
- Sub-module yacht_face_hist: serial histogram plus bad flag.
  - Inputs: clear, valid, die.
  - Output: hist array of FACES × 3-bit counts.
- Evaluation logic and the scorecard live in the top level.

## Test plan
- Roll {3,3,3,5,5}, cat=8, commit=1 → score_valid 7 cycles after req; score=25, total=25, used[8]=1.
- Repeat cat=8 with commit=1 → reject=1, total stays 25.
- FACES=8, roll {4,5,6,7,8}, cat=10 → score=40. Roll {7,7,7,7,2}, cat=7 → score=30.
- Roll {1,2,0,4,5}, cat=6 → bad_die=1, score=0; with commit=1 also reject=1.
- Commit Sixes {6,6,6,6,6}=30, Fives {5,5,5,5,5}=25, Fours {4,4,4,4,1}=16 → after the third commit total=106 and bonus_got=1. Commit all 12 categories → game_over=1.
- Assert rst in COUNT → no score_valid pulse, all outputs 0. Assert new_game and req in the same IDLE cycle → scorecard cleared, busy stays 0.
